// File: rtl/myriadrf_pkg.sv
// Shared types and helpers for the MyriadRF sample-stream framers.
// Holds the framer state encoding, the I/Q packing helper and channel-width constants.
package myriadrf_pkg;

   localparam int MAX_NCH = 4;
   localparam int CHW_MAX = $clog2(MAX_NCH);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      GET_I  = 2'd1,
      GET_Q  = 2'd2,
      GET_I0 = 2'd3
   } state_t;

   // Bit-sliced so it works for any sample width: returns {upper, lower} for one bit position.
   function automatic logic [1:0] pack_iq_bit(input logic i_bit, input logic q_bit,
                                              input logic swap);
      return swap ? {i_bit, q_bit} : {q_bit, i_bit};
   endfunction

endpackage

// File: rtl/myriadrf_stream_outreg.sv
// Single-entry ready/valid output register that drops and counts words arriving while full.
// Shared between the RX and TX sample paths.
module myriadrf_stream_outreg #(
   parameter int W  = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic [W-1:0]  in_data,
   input  logic          in_valid,
   output logic [W-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] drop_cnt
);

   // Handshake: a word transfers on any edge where out_valid & out_ready; while out_valid is
   // high without ready, out_data is frozen and any new in_valid word is dropped and counted.
   logic load;
   logic drop;

   assign load = in_valid & (~out_valid | out_ready);
   assign drop = in_valid & out_valid & ~out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         if (load) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (clr) begin
            drop_cnt <= '0;
         end else if (drop && (drop_cnt != {CW{1'b1}})) begin
            drop_cnt <= drop_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/myriadrf_rx_framer.sv
// Multi-channel RX framer: aligns the interleaved I/Q bus to frame sync, decimates by whole
// frames and emits one tagged {Q,I} word per channel on a ready/valid stream.
module myriadrf_rx_framer
   import myriadrf_pkg::*;
#(
   parameter int SW  = 12,
   parameter int NCH = 2,
   parameter int CHW = CHW_MAX,
   parameter int CW  = 16,
   parameter int DW  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable_i,
   input  logic              iq_swap_i,
   input  logic [DW-1:0]     decim_i,
   input  logic              clr_i,
   input  logic [SW-1:0]     rxd,
   input  logic              rxiqsel,
   input  logic              rx_fsync,
   output logic [2*SW-1:0]   m_data_o,
   output logic [CHW-1:0]    m_chan_o,
   output logic              m_last_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [CW-1:0]     ovf_cnt_o,
   output logic              sync_err_o,
   output logic              locked_o
);

   localparam logic [CHW-1:0] LAST_CHAN = CHW'(NCH - 1);
   localparam int             PW        = CHW + 1 + 2 * SW;

   state_t          state, state_nxt;
   logic [CHW-1:0]  chan, chan_nxt;
   logic [SW-1:0]   hold_i, hold_i_nxt;
   logic            keep, keep_nxt;
   logic [DW-1:0]   dec_cnt, dec_cnt_nxt;
   logic [DW-1:0]   decim_lat, decim_lat_nxt;
   logic [DW-1:0]   dec_step;
   logic            sync_err;
   logic            locked;

   logic            entry;
   logic            in_sync;
   logic            word_due;
   logic            err_set;
   logic [2*SW-1:0] word;
   logic [PW-1:0]   payload;
   logic [PW-1:0]   out_payload;

   assign entry    = enable_i & rx_fsync & rxiqsel;
   assign dec_step = (dec_cnt == decim_lat) ? '0 : dec_cnt + DW'(1);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SEARCH;
         chan      <= '0;
         hold_i    <= '0;
         keep      <= 1'b0;
         dec_cnt   <= '0;
         decim_lat <= '0;
         sync_err  <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nxt;
         chan      <= chan_nxt;
         hold_i    <= hold_i_nxt;
         keep      <= keep_nxt;
         dec_cnt   <= dec_cnt_nxt;
         decim_lat <= decim_lat_nxt;
         locked    <= (state_nxt != SEARCH);
         if (clr_i) begin
            sync_err <= 1'b0;
         end else if (err_set) begin
            sync_err <= 1'b1;
         end
      end
   end

   // Next-state logic; a mismatch that is itself a valid frame start re-locks immediately.
   always_comb begin
      state_nxt     = state;
      chan_nxt      = chan;
      hold_i_nxt    = hold_i;
      keep_nxt      = keep;
      dec_cnt_nxt   = dec_cnt;
      decim_lat_nxt = decim_lat;
      if (!enable_i) begin
         state_nxt = SEARCH;
      end else if ((state != SEARCH) && in_sync) begin
         case (state)
            GET_Q: begin
               if (chan == LAST_CHAN) begin
                  state_nxt = GET_I0;
               end else begin
                  chan_nxt  = chan + CHW'(1);
                  state_nxt = GET_I;
               end
            end
            GET_I: begin
               hold_i_nxt = rxd;
               state_nxt  = GET_Q;
            end
            GET_I0: begin
               hold_i_nxt    = rxd;
               chan_nxt      = '0;
               dec_cnt_nxt   = dec_step;
               keep_nxt      = (dec_step == '0);
               decim_lat_nxt = decim_i;
               state_nxt     = GET_Q;
            end
            default: state_nxt = SEARCH;
         endcase
      end else if (entry) begin
         hold_i_nxt    = rxd;
         chan_nxt      = '0;
         keep_nxt      = (dec_cnt == '0);
         decim_lat_nxt = decim_i;
         state_nxt     = GET_Q;
      end else begin
         state_nxt = SEARCH;
      end
   end

   // Output logic
   always_comb begin
      in_sync  = 1'b0;
      word_due = 1'b0;
      err_set  = 1'b0;
      case (state)
         GET_Q:   in_sync = ~rxiqsel;
         GET_I:   in_sync = rxiqsel & ~rx_fsync;
         GET_I0:  in_sync = rxiqsel & rx_fsync;
         default: in_sync = 1'b0;
      endcase
      if (enable_i && (state != SEARCH)) begin
         word_due = (state == GET_Q) & in_sync & keep;
         err_set  = ~in_sync;
      end
   end

   for (genvar b = 0; b < SW; b++) begin : g_pack
      assign {word[b + SW], word[b]} = pack_iq_bit(hold_i[b], rxd[b], iq_swap_i);
   end

   assign payload = {chan, (chan == LAST_CHAN), word};

   myriadrf_stream_outreg #(
      .W  (PW),
      .CW (CW)
   ) u_outreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr_i),
      .in_data   (payload),
      .in_valid  (word_due),
      .out_data  (out_payload),
      .out_valid (m_valid_o),
      .out_ready (m_ready_i),
      .drop_cnt  (ovf_cnt_o)
   );

   assign {m_chan_o, m_last_o, m_data_o} = out_payload;
   assign sync_err_o = sync_err;
   assign locked_o   = locked;

endmodule

// File: tb/tb_myriadrf_rx_framer.sv
// Bench for myriadrf_rx_framer: directed scenarios plus randomized traffic, all checked
// every cycle against a frame-position model of the framer and its output register.
module tb_myriadrf_rx_framer;
  localparam int SW  = 12;
  localparam int NCH = 2;
  localparam int CHW = 2;
  localparam int CW  = 4;
  localparam int DW  = 8;
  localparam int W   = 2 * SW;
  localparam int PW  = CHW + 1 + W;
  localparam int OVF_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b0;
  logic          iq_swap_i = 1'b0;
  logic [DW-1:0] decim_i = '0;
  logic          clr_i = 1'b0;
  logic [SW-1:0] rxd = '0;
  logic          rxiqsel = 1'b0;
  logic          rx_fsync = 1'b0;
  logic [W-1:0]  m_data_o;
  logic [CHW-1:0] m_chan_o;
  logic          m_last_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [CW-1:0] ovf_cnt_o;
  logic          sync_err_o;
  logic          locked_o;

  myriadrf_rx_framer #(.SW(SW), .NCH(NCH), .CHW(CHW), .CW(CW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .iq_swap_i(iq_swap_i),
    .decim_i(decim_i), .clr_i(clr_i), .rxd(rxd), .rxiqsel(rxiqsel), .rx_fsync(rx_fsync),
    .m_data_o(m_data_o), .m_chan_o(m_chan_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .ovf_cnt_o(ovf_cnt_o), .sync_err_o(sync_err_o), .locked_o(locked_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int             m_pos;      // next expected sample index within a frame, -1 = unaligned
  logic [SW-1:0]  m_i;
  bit             m_keep;
  int             m_dec, m_dlat;
  bit             m_serr;
  int             m_ovf;
  bit             m_hv;
  logic [W-1:0]   m_hd;
  int             m_hc;
  logic [PW-1:0]  exp_q[$];
  logic [PW-1:0]  acc_log[$];
  int             checks = 0;
  int             failures = 0;
  int             rdy_mode = 1;   // 0 = never ready, 1 = always ready, 2 = random

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_i = '0; m_keep = 0; m_dec = 0; m_dlat = 0; m_serr = 0; m_ovf = 0;
    m_hv = 0; m_hd = '0; m_hc = 0;
    exp_q.delete();
  endtask

  task automatic model_lock();
    m_dlat = int'(decim_i);
    m_keep = (m_dec == 0);
    m_i    = rxd;
    m_pos  = 1;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit           due = 0;
    logic [W-1:0] w = '0;
    int           wc = 0;
    bit           start = enable_i && rx_fsync && rxiqsel;
    if (!enable_i) begin
      m_pos = -1;
    end else if (m_pos < 0) begin
      if (start) model_lock();
    end else begin
      bit want_i = (m_pos % 2 == 0);
      bit ok = (rxiqsel == want_i) && (!want_i || (rx_fsync == (m_pos == 0)));
      if (ok) begin
        if (want_i) begin
          if (m_pos == 0) begin
            m_dec  = (m_dec == m_dlat) ? 0 : (m_dec + 1) % (1 << DW);
            m_keep = (m_dec == 0);
            m_dlat = int'(decim_i);
          end
          m_i = rxd;
          m_pos++;
        end else begin
          if (m_keep) begin
            due = 1;
            w   = iq_swap_i ? {m_i, rxd} : {rxd, m_i};
            wc  = m_pos / 2;
          end
          m_pos = (m_pos + 1) % (2 * NCH);
        end
      end else begin
        m_serr = 1;
        m_pos  = -1;
        if (start) model_lock();
      end
    end
    if (due) begin
      if (!m_hv || m_ready_i) begin
        m_hv = 1; m_hd = w; m_hc = wc;
        exp_q.push_back({CHW'(wc), (wc == NCH - 1) ? 1'b1 : 1'b0, w});
      end else if (m_ovf < OVF_MAX) begin
        m_ovf++;
      end
    end else if (m_ready_i) begin
      m_hv = 0;
    end
    if (clr_i) begin
      m_ovf = 0;
      m_serr = 0;
    end
  endtask

  task automatic compare();
    check("valid", m_valid_o, m_hv);
    if (m_hv) begin
      check("data", m_data_o, m_hd);
      check("chan", m_chan_o, m_hc);
      check("last", m_last_o, (m_hc == NCH - 1));
    end
    check("ovf_cnt", ovf_cnt_o, m_ovf);
    check("sync_err", sync_err_o, m_serr);
    check("locked", locked_o, (m_pos >= 0));
  endtask

  // One clock: scoreboard the transfer about to happen, step the model, compare after the edge.
  task automatic tick();
    if (m_valid_o && m_ready_i) begin
      logic [PW-1:0] got = {m_chan_o, m_last_o, m_data_o};
      if (exp_q.size() == 0) begin
        check("accept_unexpected", got, '0);
      end else begin
        check("accepted_word", got, exp_q.pop_front());
      end
      acc_log.push_back(got);
    end
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic put(logic [SW-1:0] d, bit iq, bit fs);
    rxd = d; rxiqsel = iq; rx_fsync = fs;
    m_ready_i = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    tick();
  endtask

  task automatic send_frame();
    put(12'h111, 1, 1); put(12'h222, 0, 0);
    put(12'h333, 1, 0); put(12'h444, 0, 0);
  endtask

  initial begin
    #2ms;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int gp;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", m_valid_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_ovf", ovf_cnt_o, 0);
    check("rst_serr", sync_err_o, 0);
    check("rst_locked", locked_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    enable_i = 1'b1;

    // Lock and basic emission
    rdy_mode = 1;
    put(12'h111, 1, 1);
    check("lock_locked", locked_o, 1);
    put(12'h222, 0, 0);
    check("lock_v0", m_valid_o, 1);
    check("lock_w0", m_data_o, 24'h222111);
    check("lock_c0", {m_chan_o, m_last_o}, {2'd0, 1'b0});
    put(12'h333, 1, 0); put(12'h444, 0, 0);
    check("lock_w1", m_data_o, 24'h444333);
    check("lock_c1", {m_chan_o, m_last_o}, {2'd1, 1'b1});
    send_frame(); send_frame();
    check("lock_log0", acc_log[0], {2'd0, 1'b0, 24'h222111});
    check("lock_log1", acc_log[1], {2'd1, 1'b1, 24'h444333});

    // Swap and decimate by 3
    iq_swap_i = 1'b1; decim_i = 8'd2;
    n0 = acc_log.size();
    repeat (6) send_frame();
    check("dec_count", acc_log.size() - n0, 5);
    check("dec_w0", acc_log[n0 + 1], {2'd0, 1'b0, 24'h111222});
    check("dec_w1", acc_log[n0 + 2], {2'd1, 1'b1, 24'h333444});
    check("dec_w3", acc_log[n0 + 4], {2'd1, 1'b1, 24'h333444});

    // Backpressure
    iq_swap_i = 1'b0; decim_i = 8'd0;
    rdy_mode = 0;
    repeat (2) send_frame();
    check("bp_held_v", m_valid_o, 1);
    check("bp_held_w", m_data_o, 24'h222111);
    check("bp_ovf", ovf_cnt_o, 3);
    rdy_mode = 1;
    repeat (2) send_frame();

    // Sync error and clear
    put(12'h111, 1, 0);
    check("se_flag", sync_err_o, 1);
    check("se_unlocked", locked_o, 0);
    put(12'h222, 0, 0); put(12'h333, 1, 0); put(12'h444, 0, 0);
    check("se_no_word", m_valid_o, 0);
    clr_i = 1'b1;
    put(12'h111, 1, 1);
    clr_i = 1'b0;
    check("se_relock", locked_o, 1);
    check("se_clr_flag", sync_err_o, 0);
    check("se_clr_ovf", ovf_cnt_o, 0);
    put(12'h222, 0, 0); put(12'h333, 1, 0); put(12'h444, 0, 0);

    // Asynchronous reset mid-frame
    rdy_mode = 0;
    send_frame();
    put(12'h111, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", m_valid_o, 0);
    check("ar_data", m_data_o, 0);
    check("ar_chanlast", {m_chan_o, m_last_o}, 0);
    check("ar_ovf", ovf_cnt_o, 0);
    check("ar_locked", locked_o, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    put(12'h222, 0, 0);
    check("ar_no_word", m_valid_o, 0);
    put(12'h111, 1, 1); put(12'h222, 0, 0);
    check("ar_first_v", m_valid_o, 1);
    check("ar_first_w", m_data_o, 24'h222111);
    put(12'h333, 1, 0); put(12'h444, 0, 0);

    // Counter saturation and clear against a concurrent drop
    rdy_mode = 0;
    repeat (10) send_frame();
    check("sat_ovf", ovf_cnt_o, OVF_MAX);
    put(12'h111, 1, 1);
    clr_i = 1'b1;
    put(12'h222, 0, 0);
    clr_i = 1'b0;
    check("sat_clr", ovf_cnt_o, 0);
    put(12'h333, 1, 0); put(12'h444, 0, 0);
    rdy_mode = 1;
    send_frame();

    // Randomized traffic
    rdy_mode = 2;
    gp = 0;
    for (int n = 0; n < 4000; n++) begin
      bit iq, fs;
      enable_i = ($urandom_range(0, 99) != 0);
      clr_i = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 199) == 0) decim_i = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) iq_swap_i = ~iq_swap_i;
      iq = (gp % 2 == 0);
      fs = (gp == 0);
      case ($urandom_range(0, 99))
        0: iq = ~iq;
        1: fs = ~fs;
        default: ;
      endcase
      put(SW'($urandom_range(0, (1 << SW) - 1)), iq, fs);
      gp = (gp + 1) % (2 * NCH);
    end
    clr_i = 1'b0;
    enable_i = 1'b1;
    rdy_mode = 1;
    repeat (4) put(12'h000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
